load_store_sched: RTL and testbench
===================================

Name: load_store_sched

Overview:
- Round-robin scheduler that shares one bounded volume counter (capacity N) among NREQ requesters.
- Each requester asks to fill (load) or drain (store) a number of units.
- The block grants one requester at a time and moves the volume one unit per cycle.
- It ends a transfer early when the volume hits its bound, and reports completion with a one-cycle done pulse carrying moved count and truncation flag.
- It sits between load/store clients and the shared volume resource.

Parameters:
- N, 25000, volume capacity (upper bound of vol).
- CBITS, 15, width of vol; must satisfy 2^CBITS > N.
- NREQ, 4, number of requesters.
- LBITS, 8, width of the per-request length and moved count.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  request pending per requester; held until done for that requester.
- req_dir  input  NREQ  1 = fill (vol up), 0 = drain (vol down); stable while req_valid=1.
- req_len  input  NREQ*LBITS  units requested; requester i uses bits [i*LBITS +: LBITS]; stable while req_valid=1.
- grant  output  NREQ  one-hot; high for the owner during every transfer cycle.
- done  output  1  one-cycle completion pulse.
- done_id  output  $clog2(NREQ)  owner index, valid while done=1.
- moved  output  LBITS  units actually moved, valid while done=1.
- trunc  output  1  transfer stopped at a bound before len was reached; valid while done=1.
- vol  output  CBITS  current volume.
- full  output  1  vol == N.
- empty  output  1  vol == 0.

Behaviour:
- Reset values: vol=0, grant=0, done=0, done_id=0, moved=0, trunc=0, state=IDLE, rr pointer=0. This gives empty=1, full=0.
- rst high in any state, including mid-transfer, aborts immediately with no done pulse.
- States: IDLE, XFER, DONE. All outputs are registered except full and empty, which decode vol.
- Eligibility: requester i is eligible if req_valid[i]=1 and not (req_dir[i]=1 and full) and not (req_dir[i]=0 and empty).
- Blocked requests are skipped, not dropped. They become eligible when vol changes.
- IDLE: if any requester is eligible, pick the first eligible index at or after the rr pointer (cyclic). At that edge, latch owner, dir and len, and set rr pointer = owner+1 mod NREQ.
  - len == 0: go to DONE with moved=0, trunc=0, grant stays 0.
  - len > 0: go to XFER with grant[owner]=1 and moved=0.
  - No eligible requester: stay in IDLE.
- XFER, every edge:
  - vol ±1 per dir; moved += 1.
  - If moved reaches len: go to DONE with trunc=0.
  - Else, if vol has reached the bound (N for fill, 0 for drain): go to DONE with trunc=1.
  - Len reached and bound reached on the same edge gives trunc=0.
- Latency: a granted len L transfer with no truncation has grant high for exactly L cycles and vol changes on each of those L edges. The done cycle follows immediately.
- vol never exceeds N and never underflows 0. moved never exceeds len.
- DONE: grant=0, done=1 for exactly one cycle, then IDLE.
  - The requester must drop req_valid at the edge ending the done cycle, so the following IDLE cycle sees it low.
  - At most one transfer is in flight. Request inputs are ignored outside IDLE.
- Simultaneous requests: strict round-robin. No requester waits more than NREQ-1 other grants while it stays eligible.
- Invariants: grant is one-hot or zero; grant != 0 only in XFER; done and grant are never high together.

Test Plan:
1. Reset, then req_valid=0001, dir=fill, len=5 → grant=0001 for 5 cycles, vol 0→5, then done=1, done_id=0, moved=5, trunc=0, grant=0.
2. vol=3, req1 drain len=10 → grant for 3 cycles, vol=0, done with moved=3, trunc=1, empty=1.
3. All four valid with fill len=2, rr pointer=0 → grants in order 0,1,2,3, vol ends at 8. Then re-raise req0 and req2 → grant 0, then 2.
4. vol=N (use small N=4 build), req0 fill len=3 and req1 drain len=2 → req0 skipped, req1 granted, vol=2. Then req0 granted, moved=2, trunc=1, vol=4.
5. req2 with len=0 → no grant; done one cycle after acceptance, moved=0, trunc=0, vol unchanged.
6. rst asserted in the 3rd cycle of a fill len=6 → next cycle vol=0, grant=0, done=0, state IDLE. The request is re-served normally after rst drops.

Source files
------------

// File: rtl/load_store_sched.sv
// Round-robin scheduler sharing one bounded volume counter among NREQ
// load/store requesters; moves one unit per cycle and reports completion.
module load_store_sched #(
  parameter int unsigned N     = 25000,
  parameter int unsigned CBITS = 15,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned LBITS = 8,
  localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_dir,
  input  logic [NREQ*LBITS-1:0] req_len,
  output logic [NREQ-1:0]       grant,
  output logic                  done,
  output logic [IDW-1:0]        done_id,
  output logic [LBITS-1:0]      moved,
  output logic                  trunc,
  output logic [CBITS-1:0]      vol,
  output logic                  full,
  output logic                  empty
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state, state_n;
  logic [IDW-1:0]    rr, rr_n;
  logic [IDW-1:0]    done_id_n;
  logic              dir_q, dir_n;
  logic [LBITS-1:0]  len_q, len_n;
  logic [LBITS-1:0]  moved_n, moved_inc;
  logic [CBITS-1:0]  vol_n, vol_step;
  logic [NREQ-1:0]   grant_n;
  logic              done_n, trunc_n;
  logic [NREQ-1:0]   elig;
  logic              pick_ok;
  logic [IDW-1:0]    pick;
  logic              at_bound;

  // Bound flags decode the volume register directly.
  assign full  = (vol == CBITS'(N));
  assign empty = (vol == '0);

  // A requester is eligible unless its direction is blocked by a bound.
  always_comb begin
    elig = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      elig[i] = req_valid[i] & ~(req_dir[i] & full) & ~(~req_dir[i] & empty);
    end
  end

  // First eligible index at or after the round-robin pointer, cyclically.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    pick_ok = 1'b0;
    pick    = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = 32'(rr) + 32'(k);
      if (idx >= NREQ) idx = idx - NREQ;
      if (elig[IDW'(idx)]) begin
        pick_ok = 1'b1;
        pick    = IDW'(idx);
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state;
    rr_n      = rr;
    done_id_n = done_id;
    dir_n     = dir_q;
    len_n     = len_q;
    moved_n   = moved;
    trunc_n   = trunc;
    vol_n     = vol;
    grant_n   = grant;
    done_n    = 1'b0;
    vol_step  = dir_q ? (vol + CBITS'(1)) : (vol - CBITS'(1));
    moved_inc = moved + LBITS'(1);
    at_bound  = dir_q ? (vol_step == CBITS'(N)) : (vol_step == '0);

    case (state)
      IDLE: begin
        grant_n = '0;
        if (pick_ok) begin
          done_id_n = pick;
          dir_n     = req_dir[pick];
          len_n     = req_len[pick*LBITS +: LBITS];
          moved_n   = '0;
          trunc_n   = 1'b0;
          rr_n      = (pick == IDW'(NREQ - 1)) ? '0 : (pick + IDW'(1));
          if (len_n == '0) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            state_n = XFER;
            grant_n = NREQ'(1) << pick;
          end
        end
      end
      XFER: begin
        vol_n   = vol_step;
        moved_n = moved_inc;
        if (moved_inc == len_q) begin
          state_n = DONE;
          grant_n = '0;
          done_n  = 1'b1;
          trunc_n = 1'b0;
        end else if (at_bound) begin
          state_n = DONE;
          grant_n = '0;
          done_n  = 1'b1;
          trunc_n = 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer without a done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr      <= '0;
      done_id <= '0;
      dir_q   <= 1'b0;
      len_q   <= '0;
      moved   <= '0;
      trunc   <= 1'b0;
      vol     <= '0;
      grant   <= '0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      rr      <= rr_n;
      done_id <= done_id_n;
      dir_q   <= dir_n;
      len_q   <= len_n;
      moved   <= moved_n;
      trunc   <= trunc_n;
      vol     <= vol_n;
      grant   <= grant_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_load_store_sched.sv
// Directed bench for load_store_sched: default-size instance plus an N=4 instance.
module tb_load_store_sched;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned LBITS = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  req_valid, req_dir, grant;
  logic [31:0] req_len;
  logic        done, trunc, full, empty;
  logic [1:0]  done_id;
  logic [7:0]  moved;
  logic [14:0] vol;

  logic [3:0]  s_req_valid, s_req_dir, s_grant;
  logic [31:0] s_req_len;
  logic        s_done, s_trunc, s_full, s_empty;
  logic [1:0]  s_done_id;
  logic [7:0]  s_moved;
  logic [2:0]  s_vol;

  int errors = 0;
  int checks = 0;

  load_store_sched #(.N(25000), .CBITS(15), .NREQ(4), .LBITS(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_dir(req_dir), .req_len(req_len),
    .grant(grant), .done(done), .done_id(done_id), .moved(moved), .trunc(trunc),
    .vol(vol), .full(full), .empty(empty)
  );

  load_store_sched #(.N(4), .CBITS(3), .NREQ(4), .LBITS(8)) dut_s (
    .clk(clk), .rst(rst), .req_valid(s_req_valid), .req_dir(s_req_dir), .req_len(s_req_len),
    .grant(s_grant), .done(s_done), .done_id(s_done_id), .moved(s_moved), .trunc(s_trunc),
    .vol(s_vol), .full(s_full), .empty(s_empty)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Steps until done, OR-ing every grant seen and counting grant cycles.
  task automatic wait_xfer(input bit sel, output logic [3:0] gs, output int n, output bit to);
    logic [3:0] g;
    logic       d;
    gs = '0;
    n  = 0;
    to = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      g = sel ? s_grant : grant;
      d = sel ? s_done : done;
      if (g != '0) begin
        gs = gs | g;
        n++;
      end
      if (d) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_dir = '0; req_len = '0;
    s_req_valid = '0; s_req_dir = '0; s_req_len = '0;
    tick(); tick();
    checks++; if (vol !== 15'd0) begin errors++; $display("FAIL rst_vol got %0d want 0", vol); end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL rst_grant got %b want 0000", grant); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL rst_done_id got %0d want 0", done_id); end
    checks++; if (moved !== 8'd0) begin errors++; $display("FAIL rst_moved got %0d want 0", moved); end
    checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL rst_trunc got %b want 0", trunc); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL rst_flags got empty=%b full=%b want 1/0", empty, full); end
    checks++; if (s_empty !== 1'b1 || s_vol !== 3'd0) begin errors++; $display("FAIL rst_small got empty=%b vol=%0d want 1/0", s_empty, s_vol); end
    rst = 1'b0;
  endtask

  task automatic test_fill();
    logic [3:0] gs; int n; bit to;
    req_dir[0] = 1'b1; req_len[7:0] = 8'd5; req_valid = 4'b0001;
    wait_xfer(1'b0, gs, n, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL fill_timeout got %b want 0", to); end
    checks++; if (gs !== 4'b0001) begin errors++; $display("FAIL fill_grant got %b want 0001", gs); end
    checks++; if (n !== 5) begin errors++; $display("FAIL fill_cycles got %0d want 5", n); end
    checks++; if (done_id !== 2'd0) begin errors++; $display("FAIL fill_done_id got %0d want 0", done_id); end
    checks++; if (moved !== 8'd5) begin errors++; $display("FAIL fill_moved got %0d want 5", moved); end
    checks++; if (trunc !== 1'b0) begin errors++; $display("FAIL fill_trunc got %b want 0", trunc); end
    checks++; if (vol !== 15'd5) begin errors++; $display("FAIL fill_vol got %0d want 5", vol); end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL fill_grant_at_done got %b want 0000", grant); end
    req_valid = '0;
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL fill_done_one_cycle got %b want 0", done); end
  endtask

  task automatic test_drain_trunc();
    logic [3:0] gs; int n; bit to;
    req_dir[1] = 1'b0; req_len[15:8] = 8'd2; req_valid = 4'b0010;
    wait_xfer(1'b0, gs, n, to);
    checks++; if (n !== 2 || to) begin errors++; $display("FAIL drain2_cycles got %0d want 2", n); end
    checks++; if (vol !== 15'd3) begin errors++; $display("FAIL drain2_vol got %0d want 3", vol); end
    req_valid = '0;
    tick();
    req_len[15:8] = 8'd10; req_valid = 4'b0010;
    wait_xfer(1'b0, gs, n, to);
    checks++; if (gs !== 4'b0010) begin errors++; $display("FAIL drain_grant got %b want 0010", gs); end
    checks++; if (n !== 3 || to) begin errors++; $display("FAIL drain_cycles got %0d want 3", n); end
    checks++; if (moved !== 8'd3) begin errors++; $display("FAIL drain_moved got %0d want 3", moved); end
    checks++; if (trunc !== 1'b1) begin errors++; $display("FAIL drain_trunc got %b want 1", trunc); end
    checks++; if (done_id !== 2'd1) begin errors++; $display("FAIL drain_done_id got %0d want 1", done_id); end
    checks++; if (vol !== 15'd0 || empty !== 1'b1) begin errors++; $display("FAIL drain_vol got vol=%0d empty=%b want 0/1", vol, empty); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_zero_len();
    logic [3:0] gs; int n; bit to;
    req_dir[2] = 1'b1; req_len[23:16] = 8'd0; req_valid = 4'b0100;
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b want 1", done); end
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL zero_grant got %b want 0000", grant); end
    checks++; if (done_id !== 2'd2) begin errors++; $display("FAIL zero_done_id got %0d want 2", done_id); end
    checks++; if (moved !== 8'd0 || trunc !== 1'b0) begin errors++; $display("FAIL zero_moved got %0d/%b want 0/0", moved, trunc); end
    checks++; if (vol !== 15'd0) begin errors++; $display("FAIL zero_vol got %0d want 0", vol); end
    req_valid = '0;
    tick();
    checks++; if (done !== 1'b0 || grant !== 4'b0) begin errors++; $display("FAIL zero_after got done=%b grant=%b want 0/0000", done, grant); end
    req_dir[3] = 1'b1; req_len[31:24] = 8'd0; req_valid = 4'b1000;
    wait_xfer(1'b0, gs, n, to);
    checks++; if (n !== 0 || to || done_id !== 2'd3) begin errors++; $display("FAIL zero3 got cycles=%0d id=%0d want 0/3", n, done_id); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] gs; int n; bit to;
    logic [3:0] exp;
    req_dir = 4'b1111;
    req_len = {8'd2, 8'd2, 8'd2, 8'd2};
    req_valid = 4'b1111;
    for (int g = 0; g < 4; g++) begin
      exp = 4'(1) << g;
      wait_xfer(1'b0, gs, n, to);
      checks++; if (gs !== exp || n !== 2 || to) begin errors++; $display("FAIL rr_grant%0d got %b/%0d want %b/2", g, gs, n, exp); end
      checks++; if (done_id !== 2'(g) || moved !== 8'd2) begin errors++; $display("FAIL rr_done%0d got id=%0d moved=%0d want %0d/2", g, done_id, moved, g); end
      req_valid[g] = 1'b0;
    end
    tick();
    checks++; if (vol !== 15'd8) begin errors++; $display("FAIL rr_vol got %0d want 8", vol); end
    req_valid = 4'b0101;
    wait_xfer(1'b0, gs, n, to);
    checks++; if (gs !== 4'b0001) begin errors++; $display("FAIL rr2_first got %b want 0001", gs); end
    req_valid[0] = 1'b0;
    wait_xfer(1'b0, gs, n, to);
    checks++; if (gs !== 4'b0100) begin errors++; $display("FAIL rr2_second got %b want 0100", gs); end
    req_valid = '0;
    tick();
    checks++; if (vol !== 15'd12) begin errors++; $display("FAIL rr2_vol got %0d want 12", vol); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] gs; int n; bit to;
    req_dir[0] = 1'b1; req_len[7:0] = 8'd6; req_valid = 4'b0001;
    tick();
    checks++; if (grant !== 4'b0001 || vol !== 15'd12) begin errors++; $display("FAIL mid_start got grant=%b vol=%0d want 0001/12", grant, vol); end
    tick(); tick();
    checks++; if (vol !== 15'd14) begin errors++; $display("FAIL mid_vol got %0d want 14", vol); end
    rst = 1'b1;
    tick();
    checks++; if (vol !== 15'd0 || empty !== 1'b1) begin errors++; $display("FAIL mid_rst_vol got %0d want 0", vol); end
    checks++; if (grant !== 4'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_rst_out got grant=%b done=%b want 0000/0", grant, done); end
    rst = 1'b0;
    wait_xfer(1'b0, gs, n, to);
    checks++; if (gs !== 4'b0001 || n !== 6 || to) begin errors++; $display("FAIL mid_reserve got %b/%0d want 0001/6", gs, n); end
    checks++; if (moved !== 8'd6 || trunc !== 1'b0 || vol !== 15'd6) begin errors++; $display("FAIL mid_result got moved=%0d trunc=%b vol=%0d want 6/0/6", moved, trunc, vol); end
    req_valid = '0;
    tick();
  endtask

  task automatic test_full_skip();
    logic [3:0] gs; int n; bit to;
    s_req_dir[3] = 1'b1; s_req_len[31:24] = 8'd4; s_req_valid = 4'b1000;
    wait_xfer(1'b1, gs, n, to);
    checks++; if (n !== 4 || to) begin errors++; $display("FAIL sfill_cycles got %0d want 4", n); end
    checks++; if (s_moved !== 8'd4 || s_trunc !== 1'b0) begin errors++; $display("FAIL sfill_edge got moved=%0d trunc=%b want 4/0", s_moved, s_trunc); end
    checks++; if (s_vol !== 3'd4 || s_full !== 1'b1) begin errors++; $display("FAIL sfill_vol got vol=%0d full=%b want 4/1", s_vol, s_full); end
    s_req_valid = '0;
    tick();
    s_req_dir[0] = 1'b1; s_req_len[7:0] = 8'd3;
    s_req_dir[1] = 1'b0; s_req_len[15:8] = 8'd2;
    s_req_valid = 4'b0011;
    wait_xfer(1'b1, gs, n, to);
    checks++; if (gs !== 4'b0010 || n !== 2 || to) begin errors++; $display("FAIL skip_grant got %b/%0d want 0010/2", gs, n); end
    checks++; if (s_vol !== 3'd2 || s_done_id !== 2'd1) begin errors++; $display("FAIL skip_vol got vol=%0d id=%0d want 2/1", s_vol, s_done_id); end
    s_req_valid[1] = 1'b0;
    wait_xfer(1'b1, gs, n, to);
    checks++; if (gs !== 4'b0001 || n !== 2 || to) begin errors++; $display("FAIL unblock_grant got %b/%0d want 0001/2", gs, n); end
    checks++; if (s_moved !== 8'd2 || s_trunc !== 1'b1) begin errors++; $display("FAIL unblock_result got moved=%0d trunc=%b want 2/1", s_moved, s_trunc); end
    checks++; if (s_vol !== 3'd4 || s_full !== 1'b1) begin errors++; $display("FAIL unblock_vol got vol=%0d full=%b want 4/1", s_vol, s_full); end
    s_req_valid = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain_trunc();
    test_zero_len();
    test_round_robin();
    test_reset_mid();
    test_full_skip();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
